// File: rtl/timer_bus_arbiter.sv
// timer_bus_arbiter: two-port round-robin arbiter in front of the d_ip_timer
// register port. Port 0 is the host, port 1 is the config/ISR engine.
// One single-beat access per IDLE -> ACCESS -> RESP pass, with bounded lock.
// Optional macro TIMER_ARB_PROT_EN: blocks port-1 writes at addr >= PROT_BASE
// and reports them on err1.
module timer_bus_arbiter #(
    parameter int unsigned       ADDR_W    = 6,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       MAX_LOCK  = 4,
    parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(6'h20)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic [ADDR_W-1:0] t_addr,
    output logic [DATA_W-1:0] t_wdata,
    output logic              t_wr_en,
    output logic              t_mod_en,
    input  logic [DATA_W-1:0] t_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

`ifdef TIMER_ARB_PROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             state_q;
    logic               owner_q;
    logic               last_grant_q;
    logic               lock_held_q;
    logic [CNT_W-1:0]   lock_cnt_q;
    logic               we_q;
    logic               prot_q;
    logic [ADDR_W-1:0]  t_addr_q;
    logic [DATA_W-1:0]  t_wdata_q;
    logic               t_wr_en_q;
    logic               t_mod_en_q;
    logic               rvalid0_q;
    logic               rvalid1_q;
    logic [DATA_W-1:0]  rdata0_q;
    logic [DATA_W-1:0]  rdata1_q;
    logic               err1_q;

    logic               any_req;
    logic               owner_req;
    logic               other_req;
    logic               win;
    logic               win_we;
    logic               win_lock;
    logic               win_other_req;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic [CNT_W-1:0]   lock_cnt_d;
    logic               prot_hit;

    // Winner selection and lock-count bookkeeping for the next grant
    always_comb begin
        any_req   = req0 | req1;
        owner_req = owner_q ? req1 : req0;
        other_req = owner_q ? req0 : req1;

        if (lock_held_q && owner_req &&
            ((lock_cnt_q < CNT_W'(MAX_LOCK)) || !other_req)) begin
            win = owner_q;
        end else if (req0 != req1) begin
            win = req1;
        end else begin
            win = ~last_grant_q;
        end

        win_we        = win ? we1    : we0;
        win_lock      = win ? lock1  : lock0;
        win_addr      = win ? addr1  : addr0;
        win_wdata     = win ? wdata1 : wdata0;
        win_other_req = win ? req0   : req1;

        // Count consecutive locked grants while the other port is waiting
        if (!win_lock || !win_other_req) begin
            lock_cnt_d = '0;
        end else if (win == owner_q) begin
            lock_cnt_d = (lock_cnt_q == CNT_W'(MAX_LOCK)) ? lock_cnt_q
                                                          : lock_cnt_q + CNT_W'(1);
        end else begin
            lock_cnt_d = CNT_W'(1);
        end

        prot_hit = PROT_EN && win && win_we && (addr1 >= PROT_BASE);
    end

    // Grant is the acceptance strobe of the IDLE cycle itself, so it is
    // decoded from the registered state; reset forces it low asynchronously.
    assign gnt0 = (state_q == S_IDLE) && !rst && any_req && !win;
    assign gnt1 = (state_q == S_IDLE) && !rst && any_req &&  win;

    // Access sequencer: latch on grant, strobe timer, return response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lock_held_q  <= 1'b0;
            lock_cnt_q   <= '0;
            we_q         <= 1'b0;
            prot_q       <= 1'b0;
            t_addr_q     <= '0;
            t_wdata_q    <= '0;
            t_wr_en_q    <= 1'b0;
            t_mod_en_q   <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            err1_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        state_q     <= S_ACCESS;
                        owner_q     <= win;
                        lock_held_q <= win_lock;
                        lock_cnt_q  <= lock_cnt_d;
                        we_q        <= win_we;
                        prot_q      <= prot_hit;
                        t_addr_q    <= win_addr;
                        t_wdata_q   <= win_wdata;
                        t_wr_en_q   <= win_we & ~prot_hit;
                        t_mod_en_q  <= ~prot_hit;
                    end
                end
                S_ACCESS: begin
                    state_q    <= S_RESP;
                    t_wr_en_q  <= 1'b0;
                    t_mod_en_q <= 1'b0;
                    if (owner_q) begin
                        rvalid1_q <= 1'b1;
                        rdata1_q  <= we_q ? '0 : t_rdata;
                        err1_q    <= prot_q;
                    end else begin
                        rvalid0_q <= 1'b1;
                        rdata0_q  <= we_q ? '0 : t_rdata;
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    last_grant_q <= owner_q;
                    rvalid0_q    <= 1'b0;
                    rvalid1_q    <= 1'b0;
                    rdata0_q     <= '0;
                    rdata1_q     <= '0;
                    err1_q       <= 1'b0;
                    prot_q       <= 1'b0;
                    t_addr_q     <= '0;
                    t_wdata_q    <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign err1     = err1_q;
    assign t_addr   = t_addr_q;
    assign t_wdata  = t_wdata_q;
    assign t_wr_en  = t_wr_en_q;
    assign t_mod_en = t_mod_en_q;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Bench for timer_bus_arbiter: directed transaction table against a simple
// timer register-file model, plus hand sequences for arbitration, lock,
// mid-access reset and request withdrawal.
module tb_timer_bus_arbiter;

`ifdef TIMER_ARB_PROT_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic       req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [5:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, err1, t_wr_en, t_mod_en;
    logic [7:0] rdata0, rdata1, t_wdata, t_rdata;
    logic [5:0] t_addr;

    int total = 0;
    int bad   = 0;

    // Timer register file model: write on strobe, combinational read
    logic [7:0] tmem [64] = '{default: 8'h00};
    always @(posedge clk) if (t_mod_en && t_wr_en) tmem[t_addr] <= t_wdata;
    assign t_rdata = tmem[t_addr];

    always #5 clk = ~clk;

    timer_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err1(err1),
        .t_addr(t_addr), .t_wdata(t_wdata), .t_wr_en(t_wr_en),
        .t_mod_en(t_mod_en), .t_rdata(t_rdata)
    );

    typedef struct {
        bit       port;
        bit       we;
        bit [5:0] addr;
        bit [7:0] wdata;
        bit [7:0] exp_rdata;
        bit       exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err1,
                    t_addr, t_wdata, t_wr_en, t_mod_en});
    endfunction

    task automatic do_reset(input bit hold_req);
        rst = 1'b1;
        req0 = hold_req; req1 = hold_req; lock0 = 1'b0; lock1 = 1'b0;
        we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0;
        @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_gnt(input bit port, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 8 && !ok; n++) begin
            @(negedge clk);
            if ((port == 1'b0 && gnt0) || (port == 1'b1 && gnt1)) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
    endtask

    // One full transaction from one port, checked through every phase
    task automatic run_txn(input int idx, input vec_t v);
        bit ok;
        if (v.port == 1'b0) begin req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
        else                begin req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
        wait_gnt(v.port, ok);
        check($sformatf("v%0d_gnt", idx), 64'(ok), 64'd1);
        check($sformatf("v%0d_gnt_other", idx), 64'(v.port ? gnt0 : gnt1), 64'd0);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_mod_en", idx), 64'(t_mod_en), 64'(!v.exp_err));
        check($sformatf("v%0d_wr_en", idx), 64'(t_wr_en), 64'(v.we && !v.exp_err));
        check($sformatf("v%0d_t_addr", idx), 64'(t_addr), 64'(v.addr));
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("v%0d_rvalid", idx), 64'(v.port ? rvalid1 : rvalid0), 64'd1);
        check($sformatf("v%0d_rdata", idx), 64'(v.port ? rdata1 : rdata0), 64'(v.exp_rdata));
        check($sformatf("v%0d_rvalid_other", idx), 64'(v.port ? rvalid0 : rvalid1), 64'd0);
        check($sformatf("v%0d_err1", idx), 64'(err1), 64'(v.exp_err));
        check($sformatf("v%0d_resp_mod_en", idx), 64'(t_mod_en), 64'd0);
        @(posedge clk); #1;
    endtask

    // Hold both requests and record which port wins each grant
    task automatic collect(input string tag, input int n, input bit lk0, input logic [7:0] exp_bits);
        int         got;
        logic [7:0] seq;
        got = 0; seq = '0;
        lock0 = lk0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        for (int c = 0; c < 80 && got < n; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                check($sformatf("%s_onehot%0d", tag, got), 64'(gnt0 & gnt1), 64'd0);
                seq[got] = gnt1;
                got++;
            end
            @(posedge clk); #1;
        end
        check($sformatf("%s_count", tag), 64'(got), 64'(n));
        for (int i = 0; i < n; i++)
            check($sformatf("%s_grant%0d", tag, i), 64'(seq[i]), 64'(exp_bits[i]));
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit seen;

        //           port  we    addr   wdata  exp_rd                err
        vecs[0]  = '{1'b0, 1'b1, 6'h04, 8'hA5, 8'h00,               1'b0};
        vecs[1]  = '{1'b1, 1'b0, 6'h04, 8'h00, 8'hA5,               1'b0};
        vecs[2]  = '{1'b1, 1'b1, 6'h10, 8'h3C, 8'h00,               1'b0};
        vecs[3]  = '{1'b0, 1'b0, 6'h10, 8'h00, 8'h3C,               1'b0};
        vecs[4]  = '{1'b0, 1'b1, 6'h3F, 8'hFF, 8'h00,               1'b0};
        vecs[5]  = '{1'b1, 1'b0, 6'h3F, 8'h00, 8'hFF,               1'b0};
        vecs[6]  = '{1'b1, 1'b1, 6'h00, 8'h01, 8'h00,               1'b0};
        vecs[7]  = '{1'b0, 1'b0, 6'h00, 8'h00, 8'h01,               1'b0};
        vecs[8]  = '{1'b1, 1'b0, 6'h05, 8'h00, 8'h00,               1'b0};
        vecs[9]  = '{1'b1, 1'b1, 6'h21, 8'h5A, 8'h00,               PE};
        vecs[10] = '{1'b0, 1'b0, 6'h21, 8'h00, PE ? 8'h00 : 8'h5A,  1'b0};
        vecs[11] = '{1'b0, 1'b1, 6'h21, 8'hC3, 8'h00,               1'b0};
        vecs[12] = '{1'b1, 1'b0, 6'h21, 8'h00, 8'hC3,               1'b0};
        vecs[13] = '{1'b1, 1'b1, 6'h20, 8'h66, 8'h00,               PE};
        vecs[14] = '{1'b0, 1'b0, 6'h20, 8'h00, PE ? 8'h00 : 8'h66,  1'b0};
        vecs[15] = '{1'b1, 1'b1, 6'h1F, 8'h99, 8'h00,               1'b0};
        vecs[16] = '{1'b0, 1'b0, 6'h1F, 8'h00, 8'h99,               1'b0};
        vecs[17] = '{1'b1, 1'b0, 6'h08, 8'h00, 8'h00,               1'b0};

        // Requests held through reset; port 0 must win first, then alternate
        do_reset(1'b1);
        collect("rr", 4, 1'b0, 8'b0000_1010);

        // Reset during ACCESS discards the write and issues no response
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'h08; wdata0 = 8'h77;
        wait_gnt(1'b0, ok);
        check("rst_acc_gnt", 64'(ok), 64'd1);
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        check("rst_acc_mod_en", 64'(t_mod_en), 64'd1);
        #1 rst = 1'b1;
        #1 check("rst_mid_outputs", all_outs(), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); seen |= rvalid0 | rvalid1; @(posedge clk); #1; end
        check("rst_no_rvalid", 64'(seen), 64'd0);

        // First request after release goes to port 0; port 1 then withdraws
        addr0 = 6'h00; addr1 = 6'h00;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        check("rst_next_gnt0", 64'(gnt0), 64'd1);
        check("rst_next_gnt1", 64'(gnt1), 64'd0);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); seen |= gnt1 | rvalid1; @(posedge clk); #1; end
        check("withdraw_p1", 64'(seen), 64'd0);

        for (int i = 0; i < 18; i++) run_txn(i, vecs[i]);

        // Locked port 0 keeps four grants, then rotation is forced
        do_reset(1'b0);
        collect("lock", 6, 1'b1, 8'b0001_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_bus_arbiter.md
Name: timer_bus_arbiter

Overview:
- Two-requester round-robin arbiter that shares the d_ip_timer register port (addr/wdata/wr_en/mod_en/rdata) between a host requester (port 0) and an autonomous config/ISR requester (port 1).
- Serialises single-beat register accesses, registers the timer read data and returns it to the owning requester.
- Supports a bounded lock so a requester can issue back-to-back accesses without interleaving.

Parameters:
- ADDR_W, 6, register address width (matches timer addr).
- DATA_W, 8, register data width (matches timer wdata/rdata).
- MAX_LOCK, 4, maximum consecutive grants to a locked owner while the other port is requesting.
- PROT_BASE, 6'h20, lowest address protected from port-1 writes (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- req0 / req1  in  1  access request; held until gnt
- we0 / we1  in  1  1 = write, 0 = read; sampled with req
- addr0 / addr1  in  ADDR_W  register address
- wdata0 / wdata1  in  DATA_W  write data
- lock0 / lock1  in  1  keep ownership for the next access
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, may drop or change req next cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: access complete
- rdata0 / rdata1  out  DATA_W  read data, valid with rvalid; 0 for writes
- err1  out  1  protection violation pulse (optional feature, else tied 0)
- t_addr  out  ADDR_W  to timer addr
- t_wdata  out  DATA_W  to timer wdata
- t_wr_en  out  1  to timer wr_en
- t_mod_en  out  1  to timer mod_en
- t_rdata  in  DATA_W  from timer rdata (combinational from t_addr)

Behaviour:
- Reset: all outputs 0, state IDLE, owner = 0, last_grant = 1 (port 0 wins first), lock_cnt = 0.
- FSM IDLE -> ACCESS -> RESP -> IDLE; each state is one cycle; max throughput is one access per 3 cycles.
- IDLE, no req: stay in IDLE, all t_* outputs 0.
- IDLE, req present: select winner, latch addr/wdata/we into the t_* registers, pulse gnt<winner> this cycle, go to ACCESS.
- Selection rules, in priority order:
  - if the current owner had lock high at its last grant, still requests, and lock_cnt < MAX_LOCK (or the other port is idle), the owner wins;
  - otherwise, if only one port requests, it wins;
  - otherwise the port != last_grant wins.
- ACCESS: t_mod_en = 1 for exactly this cycle; t_wr_en = latched we; t_addr/t_wdata stable. For reads, t_rdata is captured at the end of this cycle. Go to RESP.
- RESP: rvalid<owner> = 1; rdata<owner> = captured data (0 for writes); t_mod_en = 0; t_addr/t_wdata hold their values. Update last_grant = owner. Go to IDLE.
- lock_cnt rules:
  - increments on each consecutive grant to the same locked owner while the other port requests;
  - resets to 0 on an owner change or when lock drops;
  - saturates at MAX_LOCK, which forces rotation.
- Outputs of the non-owner port stay 0 throughout.
- Requests that arrive during ACCESS/RESP wait; req must be held until gnt. Dropping req before gnt withdraws it with no side effects.
- Simultaneous req0 and req1 on the first cycle after reset: port 0 is granted.
- rst asserted mid-access: immediate return to reset values, no rvalid issued. The timer sees t_mod_en fall asynchronously, so any partial access is discarded by the timer.

Optional Feature:
- Macro: TIMER_ARB_PROT_EN.
- Defined: a port-1 write with addr1 >= PROT_BASE is still granted and still goes through ACCESS/RESP, but t_mod_en and t_wr_en stay 0 in ACCESS. In RESP: rvalid1 = 1, rdata1 = 0, err1 = 1. Port-0 writes and all reads are unaffected.
- Undefined: no protection check; err1 is tied 0.

Test Plan:
- Port-0 write: req0=1, we0=1, addr0=6'h04, wdata0=8'hA5.
  -> gnt0 at cycle N; t_mod_en=1, t_wr_en=1, t_addr=6'h04 at N+1; rvalid0=1, rdata0=8'h00 at N+2.
- Port-1 read of 6'h04 after that write.
  -> rvalid1 at N+2 with rdata1=8'hA5; rvalid0 stays 0.
- req0 and req1 held high, no lock, 4 accesses.
  -> grants strictly alternate 0,1,0,1.
- lock0=1, req0 and req1 held high, MAX_LOCK=4.
  -> grant sequence 0,0,0,0,1,0... (rotation forced after 4 consecutive port-0 grants).
- TIMER_ARB_PROT_EN defined, port-1 write to 6'h21.
  -> gnt1 pulses; t_mod_en stays 0; at RESP err1=1, rvalid1=1, rdata1=0.
  -> the same write from port 0 completes normally.
- rst pulsed during ACCESS.
  -> all outputs 0 within the same cycle, no rvalid.
  -> next request after release is granted to port 0.
